mux3_rr_arbiter: RTL
====================

Name: mux3_rr_arbiter

Overview:
- Shares one W-bit output channel between N=3 valid/ready requesters. Each requester is a NoC port.
- Round-robin arbitration picks the requester. Once a requester wins, the grant is held until that requester's packet finishes (last flit accepted).
- The datapath is the common mux selected by the arbiter's grant index, followed by one output register stage.
- Sits in front of a router output port or a shared link.

Parameters:
- N, 3, number of requesters (localparam; this block is fixed at 3).
- W, DEFAULT_D_W (common_pkg), flit width.
- L, $clog2(N), width of the select index.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- i_valid  input  [N-1:0]  per-requester flit valid.
- i_last  input  [N-1:0]  per-requester end-of-packet marker, qualified by i_valid.
- i_data  input  [N-1:0][W-1:0]  per-requester flit.
- i_ready  output  [N-1:0]  per-requester accept; at most one bit high.
- o_valid  output  1  registered output flit valid.
- o_last  output  1  registered end-of-packet.
- o_data  output  [W-1:0]  registered flit.
- o_ready  input  1  downstream accept.

Behaviour:
- Interface: clk, single clock domain. rst is synchronous and active-high.
- Reset values:
  - o_valid=0, o_last=0, o_data=0, i_ready=0.
  - State=IDLE, priority pointer ptr=N-1, so input 0 has first priority after reset.
- Load condition: load = !o_valid | o_ready.
- Handshakes:
  - An input transfer occurs when i_valid[k] & i_ready[k].
  - An output transfer occurs when o_valid & o_ready.
- State machine, states IDLE and LOCKED, held owner index own[L-1:0]:
  - IDLE: the candidate is the first k with i_valid[k], scanning ptr+1, ptr+2, ... modulo N.
  - LOCKED: the candidate is own only. Other requesters see i_ready=0 even if own is not valid; a bubble is allowed.
- Grant: i_ready[cand] = load & i_valid[cand]; all other i_ready bits are 0. i_ready is combinational from o_ready and i_valid.
- On an input transfer from k:
  - o_data<=i_data[k], o_last<=i_last[k], o_valid<=1, ptr<=k.
  - If !i_last[k]: state<=LOCKED, own<=k. Else: state<=IDLE.
- On load with no input transfer: o_valid<=0. o_data and o_last hold their old values (don't-care when o_valid=0).
- Backpressure: while o_valid & !o_ready, o_data, o_last and o_valid are stable and all i_ready=0.
- Latency and throughput:
  - Latency is 1 cycle from input transfer to o_valid.
  - Throughput is 1 flit/cycle under continuous o_ready, including back-to-back flits from the same requester and switches between requesters.
- Select index: the mux select is driven only with values 0..N-1. When no candidate exists, select=ptr. Index 3 is never generated.
- Simultaneous requests: with all three requesting single-flit packets, grant order is 0,1,2,0,...
- Fairness: a requester is granted no later than N packets after it asserts i_valid.
- rst mid-operation: any in-flight or locked packet is dropped. State returns to IDLE, ptr to N-1, o_valid to 0. rst overrides all same-cycle transfers.
- i_last on an unlocked single flit: a one-flit packet. No lock is taken.
- Protocol assertions (simulation only):
  - $onehot0(i_ready).
  - o_data stable while o_valid & !o_ready.
  - No grant to a non-owner in LOCKED.

Decomposition:
- common_pkg:
  - Existing DEFAULT_D_W.
  - Add arb_state_e enum {ARB_IDLE, ARB_LOCKED}.
- Sub-module rr_grant_select:
  - Combinational round-robin finder, parameterised on N.
  - Inputs: req[N-1:0], ptr[L-1:0]. Outputs: found, idx[L-1:0].
- Datapath: instantiate the common mux (N, W) with s=selected idx, i=i_data, feeding the output register.
- Top module scope: FSM, pointer, and output register.

Test Plan:
1. Reset:
   - Stimulus: hold rst=1 for 2 cycles with i_valid=3'b111.
   - Required: o_valid=0 and i_ready=0 throughout. The first cycle after reset grants input 0, i_ready=3'b001.
2. Round-robin order:
   - Stimulus: all inputs valid with single-flit packets (i_last=1), data 0xA/0xB/0xC, o_ready=1.
   - Required: o_data sequence A,B,C,A,B,C on consecutive cycles. i_ready sequence 001,010,100.
3. Backpressure:
   - Stimulus: o_ready=0 for 5 cycles while o_valid=1 holding 0xB, all inputs valid.
   - Required: o_data stays 0xB and i_ready=0 throughout. After o_ready=1, the next output is 0xC.
4. Packet lock:
   - Stimulus: input 1 sends 3 flits 0x11,0x12,0x13 (last on 0x13) while inputs 0 and 2 are continuously valid.
   - Required: output 0x11,0x12,0x13, then input 2's flit, then input 0's flit. No interleaving inside the packet.
5. Single requester with gaps:
   - Stimulus: only input 2 valid, 4 single flits; then input 2 drops i_valid mid-packet for 2 cycles while locked.
   - Required: 4 consecutive outputs with no bubbles. During the drop, o_valid=0 and i_ready[0]=i_ready[1]=0.
6. Reset mid-packet:
   - Stimulus: assert rst for 1 cycle while LOCKED on input 1.
   - Required: o_valid=0 the next cycle. With all inputs valid afterwards, the first grant is input 0.

Source files
------------

// File: rtl/common_pkg.sv
// Shared definitions for the NoC datapath blocks: default flit width and the
// arbiter lock state.
package common_pkg;

  localparam int unsigned DEFAULT_D_W = 32;

  typedef enum logic [0:0] {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

endpackage

// File: rtl/common_mux.sv
// Generic N-way one-hot-free mux: output is input s, zero for an out-of-range select.
module common_mux #(
  parameter int unsigned N = 2,
  parameter int unsigned W = 8,
  localparam int unsigned L = (N > 1) ? $clog2(N) : 1
) (
  input  logic [L-1:0]        s,
  input  logic [N-1:0][W-1:0] i,
  output logic [W-1:0]        o
);

  always_comb begin
    o = '0;
    for (int k = 0; k < int'(N); k++) begin
      if (s == L'(k)) o = i[k];
    end
  end

endmodule

// File: rtl/rr_grant_select.sv
// Combinational round-robin finder: first set req bit after ptr, wrapping modulo N.
module rr_grant_select #(
  parameter int unsigned N = 3,
  localparam int unsigned L = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [L-1:0] ptr,
  output logic         found,
  output logic [L-1:0] idx
);

  always_comb begin
    int unsigned k;
    k     = 0;
    found = 1'b0;
    idx   = ptr;
    // Offset N wraps back to ptr itself, so the last winner is lowest priority.
    for (int unsigned off = 1; off <= N; off++) begin
      k = (32'(ptr) + off) % N;
      if (!found && req[k[L-1:0]]) begin
        found = 1'b1;
        idx   = k[L-1:0];
      end
    end
  end

endmodule

// File: rtl/mux3_rr_arbiter.sv
// Three-input valid/ready packet arbiter: round-robin choice, grant held until
// the winner's last flit, single registered output stage.
module mux3_rr_arbiter
  import common_pkg::*;
#(
  parameter int unsigned W = DEFAULT_D_W,
  localparam int unsigned N = 3,
  localparam int unsigned L = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        i_valid,
  input  logic [N-1:0]        i_last,
  input  logic [N-1:0][W-1:0] i_data,
  output logic [N-1:0]        i_ready,
  output logic                o_valid,
  output logic                o_last,
  output logic [W-1:0]        o_data,
  input  logic                o_ready
);

  arb_state_e   state_q, state_d;
  logic [L-1:0] own_q, own_d;
  logic [L-1:0] ptr_q, ptr_d;
  logic         valid_q, valid_d;
  logic         last_q, last_d;
  logic [W-1:0] data_q, data_d;

  logic         rr_found;
  logic [L-1:0] rr_idx;
  logic         cand_found;
  logic [L-1:0] sel;
  logic         load;
  logic         take;
  logic [W-1:0] mux_out;

  rr_grant_select #(
    .N(N)
  ) u_rr (
    .req  (i_valid),
    .ptr  (ptr_q),
    .found(rr_found),
    .idx  (rr_idx)
  );

  common_mux #(
    .N(N),
    .W(W)
  ) u_mux (
    .s(sel),
    .i(i_data),
    .o(mux_out)
  );

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    last_d  = last_q;
    data_d  = data_q;
    i_ready = '0;

    if (state_q == ARB_LOCKED) begin
      cand_found = i_valid[own_q];
      sel        = own_q;
    end else begin
      cand_found = rr_found;
      sel        = rr_idx;
    end

    load = !valid_q || o_ready;
    // Reset blocks the handshake so no flit is consumed and then dropped.
    take = !rst && load && cand_found;
    if (take) i_ready[sel] = 1'b1;

    if (load) begin
      valid_d = take;
      if (take) begin
        data_d = mux_out;
        last_d = i_last[sel];
        ptr_d  = sel;
        if (i_last[sel]) begin
          state_d = ARB_IDLE;
        end else begin
          state_d = ARB_LOCKED;
          own_d   = sel;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      own_q   <= '0;
      ptr_q   <= L'(N - 1);
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

  assign o_valid = valid_q;
  assign o_last  = last_q;
  assign o_data  = data_q;

  a_ready_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(i_ready))
    else $error("i_ready has more than one bit set");

  a_data_stable: assert property (@(posedge clk) disable iff (rst)
    (valid_q && !o_ready) |=> $stable(data_q))
    else $error("o_data changed under backpressure");

  a_lock_owner: assert property (@(posedge clk) disable iff (rst)
    (state_q == ARB_LOCKED) |-> ((i_ready & ~(N'(1) << own_q)) == '0))
    else $error("grant to non-owner while locked");

endmodule
